// File: rtl/rf_wr_sched.sv
// rf_wr_sched: merges pipeline writeback, dribbler fill and microcode writes
// onto the two register-file write ports (d, e) and registers the winners.
// Optional feature: define RF_WR_BYPASS_EN to forward in-flight write data
// from the registered write ports onto the three read ports.

module rf_wr_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_vld,
  input  logic [5:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        drib_req,
  input  logic [5:0]  drib_addr,
  input  logic [31:0] drib_data,
  output logic        drib_gnt,
  input  logic        uc_req,
  input  logic [5:0]  uc_addr,
  input  logic [31:0] uc_data,
  output logic        uc_gnt,
  output logic        we_d,
  output logic [5:0]  add_d,
  output logic [31:0] di_d,
  output logic        we_e,
  output logic [5:0]  add_e,
  output logic [31:0] di_e,
  input  logic [5:0]  rd_add_a,
  input  logic [5:0]  rd_add_b,
  input  logic [5:0]  rd_add_c,
  input  logic [31:0] rf_do_a,
  input  logic [31:0] rf_do_b,
  input  logic [31:0] rf_do_c,
  output logic [31:0] rd_a,
  output logic [31:0] rd_b,
  output logic [31:0] rd_c
);

  logic        rr;
  logic        fav_req, oth_req;
  logic [5:0]  fav_addr, oth_addr;
  logic [31:0] fav_data, oth_data;
  logic        fav_ok, oth_ok, fav_gnt, oth_gnt;
  logic        d_vld, e_vld;
  logic [5:0]  d_addr, e_addr;
  logic [31:0] d_data, e_data;

  // Reorder drib/uc into favoured/other according to the round-robin pointer.
  always_comb begin
    if (rr) begin
      fav_req  = uc_req;
      fav_addr = uc_addr;
      fav_data = uc_data;
      oth_req  = drib_req;
      oth_addr = drib_addr;
      oth_data = drib_data;
    end else begin
      fav_req  = drib_req;
      fav_addr = drib_addr;
      fav_data = drib_data;
      oth_req  = uc_req;
      oth_addr = uc_addr;
      oth_data = uc_data;
    end
  end

  // Grant decision: wb blocks its address and takes port d; the favoured
  // requester wins a single free slot; a blocked favoured requester leaves
  // the slot to the other requester so no cycle is wasted.
  always_comb begin
    fav_ok  = fav_req && !(wb_vld && (fav_addr == wb_addr));
    oth_ok  = oth_req && !(wb_vld && (oth_addr == wb_addr))
                      && !(fav_ok && (oth_addr == fav_addr));
    fav_gnt = !reset && fav_ok;
    oth_gnt = !reset && oth_ok && !(wb_vld && fav_ok);
  end

  assign drib_gnt = rr ? oth_gnt : fav_gnt;
  assign uc_gnt   = rr ? fav_gnt : oth_gnt;

  // Place granted writes on ports in precedence order: first to d, second to e.
  always_comb begin
    d_vld  = 1'b0;
    d_addr = 6'd0;
    d_data = 32'd0;
    e_vld  = 1'b0;
    e_addr = 6'd0;
    e_data = 32'd0;
    if (wb_vld && !reset) begin
      d_vld  = 1'b1;
      d_addr = wb_addr;
      d_data = wb_data;
      if (fav_gnt) begin
        e_vld  = 1'b1;
        e_addr = fav_addr;
        e_data = fav_data;
      end else if (oth_gnt) begin
        e_vld  = 1'b1;
        e_addr = oth_addr;
        e_data = oth_data;
      end
    end else if (fav_gnt) begin
      d_vld  = 1'b1;
      d_addr = fav_addr;
      d_data = fav_data;
      if (oth_gnt) begin
        e_vld  = 1'b1;
        e_addr = oth_addr;
        e_data = oth_data;
      end
    end else if (oth_gnt) begin
      d_vld  = 1'b1;
      d_addr = oth_addr;
      d_data = oth_data;
    end
  end

  // Register the write ports and advance the round-robin pointer when the
  // favoured requester was served; address/data hold across idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr    <= 1'b0;
      we_d  <= 1'b0;
      add_d <= 6'd0;
      di_d  <= 32'd0;
      we_e  <= 1'b0;
      add_e <= 6'd0;
      di_e  <= 32'd0;
    end else begin
      we_d <= d_vld;
      we_e <= e_vld;
      if (d_vld) begin
        add_d <= d_addr;
        di_d  <= d_data;
      end
      if (e_vld) begin
        add_e <= e_addr;
        di_e  <= e_data;
      end
      if (fav_gnt) rr <= ~rr;
    end
  end

`ifdef RF_WR_BYPASS_EN
  function automatic logic [31:0] bypass(input logic [5:0] ra, input logic [31:0] raw,
                                         input logic wd, input logic [5:0] ad, input logic [31:0] dd,
                                         input logic wev, input logic [5:0] ae, input logic [31:0] de);
    if (wd && (ra == ad))       return dd;
    else if (wev && (ra == ae)) return de;
    else                        return raw;
  endfunction

  // Forward data still in its RF write cycle so readers see it immediately.
  always_comb begin
    rd_a = bypass(rd_add_a, rf_do_a, we_d, add_d, di_d, we_e, add_e, di_e);
    rd_b = bypass(rd_add_b, rf_do_b, we_d, add_d, di_d, we_e, add_e, di_e);
    rd_c = bypass(rd_add_c, rf_do_c, we_d, add_d, di_d, we_e, add_e, di_e);
  end
`else
  logic unused_rd_add;
  assign unused_rd_add = ^{rd_add_a, rd_add_b, rd_add_c};
  assign rd_a = rf_do_a;
  assign rd_b = rf_do_b;
  assign rd_c = rf_do_c;
`endif

endmodule

// File: tb/tb_rf_wr_sched.sv
// tb_rf_wr_sched: randomized scoreboard bench for rf_wr_sched with a
// rule-level reference model (precedence list, free-slot count, taken-address set).

module tb_rf_wr_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_vld;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic        drib_req;
  logic [5:0]  drib_addr;
  logic [31:0] drib_data;
  logic        drib_gnt;
  logic        uc_req;
  logic [5:0]  uc_addr;
  logic [31:0] uc_data;
  logic        uc_gnt;
  logic        we_d, we_e;
  logic [5:0]  add_d, add_e;
  logic [31:0] di_d, di_e;
  logic [5:0]  rd_add_a, rd_add_b, rd_add_c;
  logic [31:0] rf_do_a, rf_do_b, rf_do_c;
  logic [31:0] rd_a, rd_b, rd_c;

  always #5 clk = ~clk;

  rf_wr_sched dut (
    .clk(clk), .reset(reset),
    .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
    .drib_req(drib_req), .drib_addr(drib_addr), .drib_data(drib_data), .drib_gnt(drib_gnt),
    .uc_req(uc_req), .uc_addr(uc_addr), .uc_data(uc_data), .uc_gnt(uc_gnt),
    .we_d(we_d), .add_d(add_d), .di_d(di_d),
    .we_e(we_e), .add_e(add_e), .di_e(di_e),
    .rd_add_a(rd_add_a), .rd_add_b(rd_add_b), .rd_add_c(rd_add_c),
    .rf_do_a(rf_do_a), .rf_do_b(rf_do_b), .rf_do_c(rf_do_c),
    .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c)
  );

  typedef struct {
    int          due;
    logic        we_d;
    logic [5:0]  add_d;
    logic [31:0] di_d;
    logic        we_e;
    logic [5:0]  add_e;
    logic [31:0] di_e;
  } wr_exp_t;

  typedef struct {
    logic dg;
    logic ug;
  } gnt_exp_t;

  wr_exp_t  wq[$];
  gnt_exp_t gq[$];
  wr_exp_t  m_reg;
  wr_exp_t  shown;
  bit       have_shown = 1'b0;
  bit       m_rr = 1'b0;
  int       cur_cyc = 0;
  int       checks = 0;
  int       passes = 0;

  bit          dp = 1'b0, up = 1'b0;
  logic [5:0]  da_p = 6'd0, ua_p = 6'd0;
  logic [31:0] dd_p = 32'd0, ud_p = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cur_cyc);
  endtask

  // Drive one cycle of inputs and push the model's expected grants and writes.
  task automatic applyStimulus(input bit rst, input bit wv, input logic [5:0] wa, input logic [31:0] wd,
                               input bit dnew, input logic [5:0] da, input logic [31:0] dd,
                               input bit unew, input logic [5:0] ua, input logic [31:0] ud,
                               input int rdb);
    logic [5:0]  taken[$];
    logic [5:0]  pa[$];
    logic [31:0] pd[$];
    bit dg = 1'b0, ug = 1'b0, fav_won = 1'b0, hit;
    int slots;
    gnt_exp_t g;
    if (!dp && dnew) begin dp = 1'b1; da_p = da; dd_p = dd; end
    if (!up && unew) begin up = 1'b1; ua_p = ua; ud_p = ud; end
    reset = rst; wb_vld = wv; wb_addr = wa; wb_data = wd;
    drib_req = dp; drib_addr = da_p; drib_data = dd_p;
    uc_req = up; uc_addr = ua_p; uc_data = ud_p;
    rd_add_a = 6'($urandom_range(0, 15));
    rd_add_b = (rdb >= 0) ? 6'(rdb) : 6'($urandom_range(0, 15));
    rd_add_c = 6'($urandom_range(0, 15));
    rf_do_a = $urandom; rf_do_b = $urandom; rf_do_c = $urandom;
    cur_cyc++;
    if (!rst) begin
      slots = wv ? 1 : 2;
      if (wv) begin taken.push_back(wa); pa.push_back(wa); pd.push_back(wd); end
      for (int k = 0; k < 2; k++) begin
        bit is_uc = (k == 0) ? m_rr : !m_rr;
        bit rq = is_uc ? up : dp;
        logic [5:0]  ad = is_uc ? ua_p : da_p;
        logic [31:0] dt = is_uc ? ud_p : dd_p;
        hit = 1'b0;
        foreach (taken[t]) if (taken[t] == ad) hit = 1'b1;
        if (rq && slots > 0 && !hit) begin
          slots--;
          taken.push_back(ad); pa.push_back(ad); pd.push_back(dt);
          if (is_uc) ug = 1'b1; else dg = 1'b1;
          if (k == 0) fav_won = 1'b1;
        end
      end
    end
    g.dg = dg; g.ug = ug;
    gq.push_back(g);
    if (rst) begin
      m_reg.we_d = 0; m_reg.add_d = 0; m_reg.di_d = 0;
      m_reg.we_e = 0; m_reg.add_e = 0; m_reg.di_e = 0;
      m_rr = 1'b0;
    end else begin
      m_reg.we_d = (pa.size() > 0);
      m_reg.we_e = (pa.size() > 1);
      if (pa.size() > 0) begin m_reg.add_d = pa[0]; m_reg.di_d = pd[0]; end
      if (pa.size() > 1) begin m_reg.add_e = pa[1]; m_reg.di_e = pd[1]; end
      if (fav_won) m_rr = ~m_rr;
    end
    m_reg.due = cur_cyc + 1;
    wq.push_back(m_reg);
    if (dg) dp = 1'b0;
    if (ug) up = 1'b0;
  endtask

  // Monitor: compare grants of this cycle and the registered write ports.
  task automatic checkOutput();
    gnt_exp_t g;
    logic [31:0] ea, eb, ec;
    if (gq.size() > 0) begin
      g = gq.pop_front();
      check("drib_gnt", drib_gnt, g.dg);
      check("uc_gnt", uc_gnt, g.ug);
    end
    if (wq.size() > 0 && wq[0].due == cur_cyc) begin
      shown = wq.pop_front();
      have_shown = 1'b1;
      check("we_d", we_d, shown.we_d);
      check("we_e", we_e, shown.we_e);
      check("add_d", add_d, shown.add_d);
      check("di_d", di_d, shown.di_d);
      check("add_e", add_e, shown.add_e);
      check("di_e", di_e, shown.di_e);
      if (shown.we_d && shown.we_e) check("d_e_distinct", add_d == add_e, 0);
    end
    if (have_shown) begin
      ea = rf_do_a; eb = rf_do_b; ec = rf_do_c;
`ifdef RF_WR_BYPASS_EN
      if (shown.we_d && rd_add_a == shown.add_d) ea = shown.di_d;
      else if (shown.we_e && rd_add_a == shown.add_e) ea = shown.di_e;
      if (shown.we_d && rd_add_b == shown.add_d) eb = shown.di_d;
      else if (shown.we_e && rd_add_b == shown.add_e) eb = shown.di_e;
      if (shown.we_d && rd_add_c == shown.add_d) ec = shown.di_d;
      else if (shown.we_e && rd_add_c == shown.add_e) ec = shown.di_e;
`endif
      check("rd_a", rd_a, ea);
      check("rd_b", rd_b, eb);
      check("rd_c", rd_c, ec);
    end
  endtask

  always @(negedge clk) checkOutput();

  task automatic step(input bit rst, input bit wv, input logic [5:0] wa, input logic [31:0] wd,
                      input bit dnew, input logic [5:0] da, input bit unew, input logic [5:0] ua,
                      input int rdb);
    @(posedge clk);
    #1;
    applyStimulus(rst, wv, wa, wd, dnew, da, $urandom, unew, ua, $urandom, rdb);
  endtask

  initial begin
    reset = 1'b1; wb_vld = 0; wb_addr = 0; wb_data = 0;
    drib_req = 0; drib_addr = 0; drib_data = 0;
    uc_req = 0; uc_addr = 0; uc_data = 0;
    rd_add_a = 0; rd_add_b = 0; rd_add_c = 0;
    rf_do_a = 0; rf_do_b = 0; rf_do_c = 0;
    m_reg.we_d = 0; m_reg.add_d = 0; m_reg.di_d = 0;
    m_reg.we_e = 0; m_reg.add_e = 0; m_reg.di_e = 0;
    m_reg.due = 1;
    wq.push_back(m_reg);

    step(1, 0, 0, 0, 0, 0, 0, 0, -1);
    step(1, 0, 0, 0, 0, 0, 0, 0, -1);
    step(0, 1, 6'd5, 32'hDEADBEEF, 0, 0, 0, 0, -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, -1);
    step(0, 1, 6'd3, $urandom, 1, 6'd7, 1, 6'd9, -1);
    step(0, 1, 6'd3, $urandom, 1, 6'd7, 1, 6'd9, -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, -1);
    step(0, 0, 0, 0, 1, 6'd10, 1, 6'd11, -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, -1);
    step(0, 1, 6'd20, $urandom, 1, 6'd20, 0, 0, -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, -1);
    step(1, 1, 6'd29, $urandom, 1, 6'd30, 1, 6'd31, -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, -1);
    @(posedge clk); #1;
    applyStimulus(0, 1, 6'd12, 32'h1234, 0, 0, 0, 0, 0, 0, -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 12);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
           6'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 6), 6'($urandom_range(0, 7)),
           ($urandom_range(0, 9) < 6), 6'($urandom_range(0, 7)), -1);
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, -1);
    @(negedge clk);
    #1;
    check("gnt_queue_drained", gq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
